// File: rtl/link_pair_receiver.sv
// rtl/link_pair_receiver.sv - two-pair differential link receiver: training, sync alignment, byte deserialiser, 2-entry output buffer
// Optional feature macro: LINK_RX_ERR_COUNT_EN (adds ErrorCount[15:0])
module link_pair_receiver #(
  parameter int         TRAIN_LEN     = 16,
  parameter int         ALIGN_TIMEOUT = 256,
  parameter int         ERR_LIMIT     = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hD5
) (
  input  logic        Clock100MhzP,
  input  logic        ResetN,
  input  logic        TIA_568B12,
  input  logic        TIA_568B36,
  input  logic        TIA_568B54,
  input  logic        TIA_568B78,
  output logic [7:0]  RxData,
  output logic        RxValid,
  input  logic        RxReady,
  output logic        LinkUp,
  output logic [1:0]  LinkState,
  output logic [1:0]  PolaritySwap,
`ifdef LINK_RX_ERR_COUNT_EN
  output logic [15:0] ErrorCount,
`endif
  output logic        Overflow,
  input  logic        ClearOverflow
);

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    TRAINING  = 2'd1,
    ALIGN     = 2'd2,
    LINK_UP   = 2'd3
  } state_t;

  localparam int TCNT_W = $clog2(TRAIN_LEN + 1);
  localparam int ACNT_W = $clog2(ALIGN_TIMEOUT + 1);
  localparam int ECNT_W = $clog2(ERR_LIMIT + 1);
  localparam logic [TCNT_W-1:0] TRAIN_LAST = TCNT_W'(TRAIN_LEN - 1);
  localparam logic [ACNT_W-1:0] ALIGN_LAST = ACNT_W'(ALIGN_TIMEOUT - 1);
  localparam logic [ECNT_W-1:0] ERR_LAST   = ECNT_W'(ERR_LIMIT - 1);
  // Lane A carries the even sync bits, lane B the odd ones, oldest in the LSB.
  localparam logic [3:0] SYNC_A = {SYNC_BYTE[6], SYNC_BYTE[4], SYNC_BYTE[2], SYNC_BYTE[0]};
  localparam logic [3:0] SYNC_B = {SYNC_BYTE[7], SYNC_BYTE[5], SYNC_BYTE[3], SYNC_BYTE[1]};

  state_t             state, state_nxt;
  logic               a_p_q, a_n_q, b_p_q, b_n_q;
  logic               a_prev, b_prev;
  logic [7:0]         shreg;
  logic [TCNT_W-1:0]  train_cnt;
  logic [ACNT_W-1:0]  align_cnt;
  logic [ECNT_W-1:0]  err_cnt;
  logic [1:0]         phase;
  logic               byte_bad;
  logic [1:0]         pol;
  logic [7:0]         head, tail;
  logic [1:0]         count;
  logic               ovf;

  logic               a_ok, b_ok, both_ok, train_good;
  logic               a_bit, b_bit;
  logic [7:0]         shreg_nxt;
  logic [3:0]         win_a, win_b;
  logic               sync_hit, byte_bad_nxt;
  logic               train_inc, sync_take, leave_up, byte_push;
  logic               pop, ovf_set;

  // Symbol decode: a lane is valid only when its legs differ; P carries the bit.
  assign a_ok    = a_p_q ^ a_n_q;
  assign b_ok    = b_p_q ^ b_n_q;
  assign both_ok = a_ok & b_ok;
  assign train_good = both_ok & (a_p_q != a_prev) & (b_p_q != b_prev);

  // Polarity is zero outside LINK_UP, so ALIGN always sees raw lane bits.
  assign a_bit     = a_p_q ^ pol[0];
  assign b_bit     = b_p_q ^ pol[1];
  assign shreg_nxt = {b_bit, a_bit, shreg[7:2]};
  assign win_a     = {shreg_nxt[6], shreg_nxt[4], shreg_nxt[2], shreg_nxt[0]};
  assign win_b     = {shreg_nxt[7], shreg_nxt[5], shreg_nxt[3], shreg_nxt[1]};
  assign sync_hit  = ((win_a == SYNC_A) || (win_a == ~SYNC_A)) &&
                     ((win_b == SYNC_B) || (win_b == ~SYNC_B));

  assign byte_bad_nxt = ((phase == 2'd0) ? 1'b0 : byte_bad) | ~both_ok;

  assign pop     = (count != 2'd0) && RxReady;
  assign ovf_set = byte_push && (count == 2'd2) && !pop;

  // Input stage: register both legs of each pair once and remember last bits.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN) begin
      a_p_q  <= 1'b0;
      a_n_q  <= 1'b0;
      b_p_q  <= 1'b0;
      b_n_q  <= 1'b0;
      a_prev <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      a_p_q  <= TIA_568B12;
      a_n_q  <= TIA_568B36;
      b_p_q  <= TIA_568B54;
      b_n_q  <= TIA_568B78;
      a_prev <= a_p_q;
      b_prev <= b_p_q;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN) state <= LINK_DOWN;
    else         state <= state_nxt;
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    train_inc = 1'b0;
    sync_take = 1'b0;
    leave_up  = 1'b0;
    byte_push = 1'b0;
    case (state)
      LINK_DOWN: begin
        if (both_ok) state_nxt = TRAINING;
      end
      TRAINING: begin
        if (!train_good)                state_nxt = LINK_DOWN;
        else if (train_cnt == TRAIN_LAST) state_nxt = ALIGN;
        else                            train_inc = 1'b1;
      end
      ALIGN: begin
        if (!both_ok) begin
          state_nxt = LINK_DOWN;
        end else if (sync_hit) begin
          sync_take = 1'b1;
          state_nxt = LINK_UP;
        end else if (align_cnt == ALIGN_LAST) begin
          state_nxt = LINK_DOWN;
        end
      end
      LINK_UP: begin
        if (!both_ok && (err_cnt == ERR_LAST)) begin
          state_nxt = LINK_DOWN;
          leave_up  = 1'b1;
        end else if ((phase == 2'd3) && !byte_bad_nxt) begin
          byte_push = 1'b1;
        end
      end
      default: state_nxt = LINK_DOWN;
    endcase
  end

  // Counters, deserialiser, byte phase and polarity latches.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN) begin
      shreg     <= '0;
      train_cnt <= '0;
      align_cnt <= '0;
      err_cnt   <= '0;
      phase     <= 2'd0;
      byte_bad  <= 1'b0;
      pol       <= 2'b00;
    end else begin
      shreg     <= shreg_nxt;
      train_cnt <= train_inc ? train_cnt + 1'b1 : '0;
      align_cnt <= (state == ALIGN) ? align_cnt + 1'b1 : '0;
      err_cnt   <= ((state == LINK_UP) && !both_ok) ? err_cnt + 1'b1 : '0;
      byte_bad  <= (state == LINK_UP) ? byte_bad_nxt : 1'b0;
      if (sync_take)              phase <= 2'd0;
      else if (state == LINK_UP)  phase <= phase + 2'd1;
      else                        phase <= 2'd0;
      if (sync_take)     pol <= {win_b == ~SYNC_B, win_a == ~SYNC_A};
      else if (leave_up) pol <= 2'b00;
    end
  end

  // Two-entry output buffer; head drives the consumer port directly.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (leave_up) begin
      count <= 2'd0;
    end else begin
      case ({byte_push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            head <= shreg_nxt;
          end else begin
            head <= tail;
            tail <= shreg_nxt;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            head  <= shreg_nxt;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= shreg_nxt;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN)            ovf <= 1'b0;
    else if (ovf_set)       ovf <= 1'b1;
    else if (ClearOverflow) ovf <= 1'b0;
  end

`ifdef LINK_RX_ERR_COUNT_EN
  logic [15:0] err_total;

  // Saturating count of invalid-symbol cycles while the link is up.
  always_ff @(posedge Clock100MhzP or negedge ResetN) begin
    if (!ResetN) err_total <= '0;
    else if ((state == LINK_UP) && !both_ok && (err_total != 16'hFFFF))
      err_total <= err_total + 16'd1;
  end

  assign ErrorCount = err_total;
`endif

  assign RxData       = head;
  assign RxValid      = (count != 2'd0);
  assign LinkUp       = (state == LINK_UP);
  assign LinkState    = state;
  assign PolaritySwap = pol;
  assign Overflow     = ovf;

endmodule

// File: tb/tb_link_pair_receiver.sv
// tb/tb_link_pair_receiver.sv - randomized scoreboard bench for link_pair_receiver
`timescale 1ns/1ps
module tb_link_pair_receiver;

  localparam logic [7:0] SYNC = 8'hD5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_p, a_n, b_p, b_n;
  logic       rx_ready, clr_ovf;
  logic [7:0] rx_data;
  logic       rx_valid, link_up, ovf;
  logic [1:0] link_state, pol;
`ifdef LINK_RX_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  logic       swap_a, swap_b;
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  link_pair_receiver dut (
    .Clock100MhzP (clk),
    .ResetN       (rst_n),
    .TIA_568B12   (a_p),
    .TIA_568B36   (a_n),
    .TIA_568B54   (b_p),
    .TIA_568B78   (b_n),
    .RxData       (rx_data),
    .RxValid      (rx_valid),
    .RxReady      (rx_ready),
    .LinkUp       (link_up),
    .LinkState    (link_state),
    .PolaritySwap (pol),
`ifdef LINK_RX_ERR_COUNT_EN
    .ErrorCount   (err_count),
`endif
    .Overflow     (ovf),
    .ClearOverflow(clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must be the oldest byte the model expects.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got byte %0h expected no byte", rx_data);
      end else begin
        check("rx_byte", rx_data, exp_q.pop_front());
      end
    end
  end

  // Code: {1'b0, bit} = symbol, {1'b1, x} = invalid with both legs at x.
  task automatic drive_pair(input logic [1:0] a, input logic [1:0] b);
    if (a[1]) begin a_p = a[0]; a_n = a[0]; end
    else begin a_p = a[0] ^ swap_a; a_n = ~(a[0] ^ swap_a); end
    if (b[1]) begin b_p = b[0]; b_n = b[0]; end
    else begin b_p = b[0] ^ swap_b; b_n = ~(b[0] ^ swap_b); end
    @(posedge clk); #1;
  endtask

  // Good bytes on an up link are expected unless the buffer is full and stalled.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] bad_a,
                           input logic [3:0] bad_b, input bit model_up);
    if (model_up && bad_a == 4'd0 && bad_b == 4'd0) begin
      if (!(rx_ready == 1'b0 && exp_q.size() >= 2)) exp_q.push_back(d);
    end
    for (int i = 0; i < 4; i++)
      drive_pair(bad_a[i] ? 2'b10 : {1'b0, d[2*i]}, bad_b[i] ? 2'b11 : {1'b0, d[2*i+1]});
  endtask

  // One discarded byte (invalid second pair); optional ClearOverflow on its first pair.
  task automatic filler(input bit clr_first);
    for (int i = 0; i < 4; i++) begin
      clr_ovf = (i == 0) ? clr_first : 1'b0;
      drive_pair((i == 1) ? 2'b10 : 2'b00, 2'b00);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic bring_up(input logic sa, input logic sb);
    swap_a = sa;
    swap_b = sb;
    for (int i = 0; i < 4; i++) drive_pair(2'b10, 2'b10);
    for (int i = 0; i < 22; i++) begin
      drive_pair({1'b0, i[0]}, {1'b0, i[0]});
      if (i == 3) check("training_state", link_state, 2'd1);
    end
    check("align_state", link_state, 2'd2);
    send_byte(SYNC, 4'd0, 4'd0, 1'b0);
    check("align_hold", link_state, 2'd2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_pair(2'b10, 2'b10);
    drive_pair(2'b10, 2'b10);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send_3c_a5(input logic [1:0] exp_pol);
    logic [7:0] d;
    d = 8'h3C;
    exp_q.push_back(d);
    for (int i = 0; i < 4; i++) begin
      drive_pair({1'b0, d[2*i]}, {1'b0, d[2*i+1]});
      if (i == 0) check("linkup_state", link_state, 2'd3);
    end
    check("lat_3c_not_yet", rx_valid, 1'b0);
    d = 8'hA5;
    exp_q.push_back(d);
    for (int i = 0; i < 4; i++) begin
      drive_pair({1'b0, d[2*i]}, {1'b0, d[2*i+1]});
      if (i == 0) begin
        check("lat_3c_valid", rx_valid, 1'b1);
        check("lat_3c_data", rx_data, 8'h3C);
      end
    end
    check("lat_a5_not_yet", rx_valid, 1'b0);
    filler(1'b0);
    check("polarity", pol, exp_pol);
    check("linkup", link_up, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  after;
    logic [7:0]  d;
    logic [3:0]  ba, bb;
    logic        sa, sb;
    int          run;
    bit          done;

    rst_n = 1'b0; rx_ready = 1'b1; clr_ovf = 1'b0;
    swap_a = 1'b0; swap_b = 1'b0;
    a_p = 1'b0; a_n = 1'b0; b_p = 1'b0; b_n = 1'b0;
    drive_pair(2'b10, 2'b10);
    drive_pair(2'b10, 2'b10);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_linkup", link_up, 1'b0);
    check("rst_state", link_state, 2'd0);
    check("rst_pol", pol, 2'b00);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // Plain link, then lane A legs swapped.
    bring_up(1'b0, 1'b0);
    send_3c_a5(2'b00);
    do_reset();
    bring_up(1'b1, 1'b0);
    send_3c_a5(2'b01);

    // Stalled consumer: overflow, clear, and clear colliding with a new drop.
    rx_ready = 1'b0;
    send_byte(8'h11, 4'd0, 4'd0, 1'b1);
    send_byte(8'h22, 4'd0, 4'd0, 1'b1);
    send_byte(8'h33, 4'd0, 4'd0, 1'b1);
    filler(1'b0);
    check("ovf_set", ovf, 1'b1);
    check("ovf_head_valid", rx_valid, 1'b1);
    check("ovf_head_data", rx_data, 8'h11);
    filler(1'b1);
    check("ovf_cleared", ovf, 1'b0);
    send_byte(8'h44, 4'd0, 4'd0, 1'b1);
    filler(1'b1);
    check("ovf_set_beats_clear", ovf, 1'b1);
    filler(1'b1);
    check("ovf_cleared2", ovf, 1'b0);
    rx_ready = 1'b1;
    filler(1'b0);
    filler(1'b0);
    check("ovf_drained", exp_q.size(), 0);

    // Invalid lane B: 3 cycles drops one byte, 4 cycles drops the link.
    send_byte(8'h5A, 4'd0, 4'b0111, 1'b1);
    send_byte(8'h96, 4'd0, 4'd0, 1'b1);
    check("err3_linkup", link_up, 1'b1);
    rx_ready = 1'b0;
    send_byte(8'hC3, 4'd0, 4'd0, 1'b1);
    send_byte(8'h00, 4'd0, 4'b1111, 1'b1);
    drive_pair(2'b10, 2'b10);
    exp_q.delete();
    check("err4_linkup", link_up, 1'b0);
    check("err4_state", link_state, 2'd0);
    check("err4_flushed", rx_valid, 1'b0);
    check("err4_pol", pol, 2'b00);
    rx_ready = 1'b1;

    // No sync after training: ALIGN must last exactly the timeout.
    swap_a = 1'b0; swap_b = 1'b0;
    run = 0; after = 2'b11; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      drive_pair({1'b0, i[0]}, {1'b0, i[0]});
      if (link_state == 2'd2) run++;
      else if (run > 0) begin after = link_state; done = 1; end
    end
    check("align_timeout_cycles", run, 256);
    check("align_timeout_state", after, 2'd0);

    // Asynchronous reset mid-byte with a byte buffered.
    bring_up(1'b0, 1'b1);
    rx_ready = 1'b0;
    send_byte(8'h77, 4'd0, 4'd0, 1'b1);
    drive_pair(2'b01, 2'b00);
    drive_pair(2'b00, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", rx_valid, 1'b0);
    check("arst_data", rx_data, 8'h00);
    check("arst_linkup", link_up, 1'b0);
    check("arst_state", link_state, 2'd0);
    check("arst_pol", pol, 2'b00);
    check("arst_ovf", ovf, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    drive_pair(2'b10, 2'b10);
    rst_n = 1'b1;
    drive_pair(2'b10, 2'b10);
    check("arst_after_state", link_state, 2'd0);
    rx_ready = 1'b1;
    bring_up(1'b1, 1'b1);
    send_byte(8'hE1, 4'd0, 4'd0, 1'b1);
    filler(1'b0);
    check("arst_relink_pol", pol, 2'b11);

    // Randomized traffic over random polarities with sporadic bad symbols.
    for (int it = 0; it < 4; it++) begin
      send_byte(8'h00, 4'b1111, 4'b1111, 1'b1);
      drive_pair(2'b10, 2'b10);
      check("rand_dropped", link_up, 1'b0);
      check("rand_all_seen", exp_q.size(), 0);
      sa = 1'($urandom);
      sb = 1'($urandom);
      bring_up(sa, sb);
      for (int k = 0; k < 10; k++) begin
        d  = 8'($urandom);
        ba = 4'd0;
        bb = 4'd0;
        case ($urandom_range(0, 5))
          0: ba = 4'b0010;
          1: bb = 4'b0100;
          2: begin ba = 4'b0100; bb = 4'b0010; end
          default: ;
        endcase
        send_byte(d, ba, bb, 1'b1);
      end
      check("rand_pol", pol, {sb, sa});
      check("rand_linkup", link_up, 1'b1);
    end
    filler(1'b0);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
